id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register with operand forwarding for the 5-stage RISC-V core. It captures decoded operands and control from ID, and drives the forwarded operands alu_op_ex, rD1_ex and alu_b_ex straight into the EX shifter and ALU. It also detects load-use hazards, and it keeps held operands coherent while the pipeline is stalled.

Parameters:
XLEN, 32, datapath width
REGW, 5, register index width
OPW, 5, ALU opcode width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active low
stall  in  1  hold ID/EX contents
flush  in  1  load a bubble into ID/EX
valid_id  in  1  ID holds a real instruction
alu_op_id  in  OPW  ALU/shift opcode
rD1_id  in  XLEN  regfile read data, rs1
rD2_id  in  XLEN  regfile read data, rs2
imm_id  in  XLEN  immediate, unmodified (bit 10 = srai flag)
alu_bsel_id  in  1  1 = operand B is the immediate
rs1_id  in  REGW  rs1 index
rs2_id  in  REGW  rs2 index
rd_id  in  REGW  destination index
rf_we_id  in  1  register write enable
mem_rd_id  in  1  instruction is a load
rd_mem  in  REGW  EX/MEM destination
rf_we_mem  in  1  EX/MEM write enable
mem_rd_mem  in  1  EX/MEM instruction is a load (not forwardable)
wd_mem  in  XLEN  EX/MEM ALU result
rd_wb  in  REGW  MEM/WB destination
rf_we_wb  in  1  MEM/WB write enable
wd_wb  in  XLEN  writeback data
valid_ex  out  1  EX holds a real instruction
alu_op_ex  out  OPW  registered opcode
rD1_ex  out  XLEN  forwarded operand A
rD2_fwd_ex  out  XLEN  forwarded rs2 data, used as store data
alu_b_ex  out  XLEN  operand B: imm_ex if bsel_ex, else rD2_fwd_ex
rd_ex  out  REGW  registered destination
rf_we_ex  out  1  registered write enable, gated by valid
mem_rd_ex  out  1  registered load flag, gated by valid
load_use_stall  out  1  hazard request to the stall controller

Behaviour:
- Registers are valid, alu_op, rD1, rD2, imm, bsel, rs1, rs2, rd, rf_we and mem_rd, all in the _ex domain. They update on the rising edge of clk only.
- rst_n=0 at an edge clears every register to 0. After reset: valid_ex=0, alu_op_ex=0, rD1_ex=0, alu_b_ex=0, rf_we_ex=0, mem_rd_ex=0, load_use_stall=0.
- Update priority per edge: reset > flush > stall > load.
  - flush: clear valid, rf_we, mem_rd and alu_op. Data registers are don't-care but are also cleared to 0.
  - stall (no flush): hold every register, with one exception. If rf_we_wb=1, rd_wb!=0 and rd_wb==rs1_ex, load wd_wb into rD1. Apply the same rule to rD2 against rs2_ex. This stops a held operand from going stale once WB retires.
  - otherwise: capture every _id input.
- Latency: one cycle from the ID inputs to the registered outputs.
- Forwarding is combinational from the registered operands and applies to both rD1 and rD2.
  - Source MEM is selected when rf_we_mem=1, mem_rd_mem=0, rd_mem!=0 and rd_mem equals the source index. MEM has priority over WB.
  - Source WB is selected when rf_we_wb=1, rd_wb!=0 and rd_wb equals the source index.
  - If neither matches, use the registered value.
- Register x0 is never forwarded; its operand stays the registered value.
- alu_b_ex = bsel_ex ? imm_ex : rD2_fwd_ex. imm_ex is passed in full, so the shifter sees shamt in bits [4:0] and the srai flag in bit 10.
- rf_we_ex = rf_we & valid and mem_rd_ex = mem_rd & valid.
- load_use_stall = mem_rd_ex & valid_ex & (rd_ex!=0) & ((rd_ex==rs1_id) | (rd_ex==rs2_id)) & valid_id.
  - It is combinational.
  - The controller responds by asserting stall on IF/ID and flush on this stage. That inserts one bubble, after which the loaded value reaches the instruction through WB forwarding.
- flush together with stall: flush wins and a bubble is loaded.
- Reset asserted mid-stall: everything clears and the stall is not remembered.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with the ID inputs active -> all outputs 0. Release, present alu_op_id=5'b00100, rD1_id=32'h8000_0000, imm_id=32'h0000_0404, bsel=1 -> the next cycle gives alu_b_ex=32'h404 and rD1_ex=32'h8000_0000.
- MEM forwarding: rs1_ex=3, rd_mem=3, rf_we_mem=1, wd_mem=32'hDEAD_BEEF. Also rd_wb=3 with wd_wb=32'h1111_1111 -> rD1_ex=32'hDEAD_BEEF (MEM priority).
- x0 guard: rs2_ex=0, rd_mem=0, rf_we_mem=1, wd_mem=32'hFFFF_FFFF, bsel=0 -> alu_b_ex equals the registered rD2 (0).
- Load-use: load in EX with rd_ex=5, valid_id=1, rs2_id=5 -> load_use_stall=1. Repeat with rd_ex=0 or mem_rd_ex=0 -> 0. Then stall+flush for one cycle -> valid_ex=0 and rf_we_ex=0.
- Stall refresh: stall=1 for 3 cycles with rs1_ex=7. On cycle 2, WB writes rd_wb=7, wd_wb=32'h0000_00AA. Once the WB forward ends -> rD1_ex stays 32'hAA and the released instruction uses 32'hAA.
- Flush priority: flush=1 and stall=1 with valid_id=1 -> valid_ex=0 and alu_op_ex=0 on the next cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use hazard
// detection and writeback refresh of held operands during stalls.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid_id,
    input  logic [OPW-1:0]  alu_op_id,
    input  logic [XLEN-1:0] rD1_id,
    input  logic [XLEN-1:0] rD2_id,
    input  logic [XLEN-1:0] imm_id,
    input  logic            alu_bsel_id,
    input  logic [REGW-1:0] rs1_id,
    input  logic [REGW-1:0] rs2_id,
    input  logic [REGW-1:0] rd_id,
    input  logic            rf_we_id,
    input  logic            mem_rd_id,
    input  logic [REGW-1:0] rd_mem,
    input  logic            rf_we_mem,
    input  logic            mem_rd_mem,
    input  logic [XLEN-1:0] wd_mem,
    input  logic [REGW-1:0] rd_wb,
    input  logic            rf_we_wb,
    input  logic [XLEN-1:0] wd_wb,
    output logic            valid_ex,
    output logic [OPW-1:0]  alu_op_ex,
    output logic [XLEN-1:0] rD1_ex,
    output logic [XLEN-1:0] rD2_fwd_ex,
    output logic [XLEN-1:0] alu_b_ex,
    output logic [REGW-1:0] rd_ex,
    output logic            rf_we_ex,
    output logic            mem_rd_ex,
    output logic            load_use_stall
);

    logic            r_valid;
    logic [OPW-1:0]  r_alu_op;
    logic [XLEN-1:0] r_rd1;
    logic [XLEN-1:0] r_rd2;
    logic [XLEN-1:0] r_imm;
    logic            r_bsel;
    logic [REGW-1:0] r_rs1;
    logic [REGW-1:0] r_rs2;
    logic [REGW-1:0] r_rd;
    logic            r_rf_we;
    logic            r_mem_rd;

    logic w_mem_hit_rs1;
    logic w_mem_hit_rs2;
    logic w_wb_hit_rs1;
    logic w_wb_hit_rs2;

    // A load still in MEM has no data yet, so it never qualifies as a MEM source.
    assign w_mem_hit_rs1 = rf_we_mem && !mem_rd_mem && (rd_mem != '0) && (rd_mem == r_rs1);
    assign w_mem_hit_rs2 = rf_we_mem && !mem_rd_mem && (rd_mem != '0) && (rd_mem == r_rs2);
    assign w_wb_hit_rs1  = rf_we_wb && (rd_wb != '0) && (rd_wb == r_rs1);
    assign w_wb_hit_rs2  = rf_we_wb && (rd_wb != '0) && (rd_wb == r_rs2);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_valid  <= 1'b0;
            r_alu_op <= '0;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_imm    <= '0;
            r_bsel   <= 1'b0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_rf_we  <= 1'b0;
            r_mem_rd <= 1'b0;
        end else if (stall) begin
            // Absorb WB results so a held operand is not stale once WB retires.
            if (w_wb_hit_rs1) r_rd1 <= wd_wb;
            if (w_wb_hit_rs2) r_rd2 <= wd_wb;
        end else begin
            r_valid  <= valid_id;
            r_alu_op <= alu_op_id;
            r_rd1    <= rD1_id;
            r_rd2    <= rD2_id;
            r_imm    <= imm_id;
            r_bsel   <= alu_bsel_id;
            r_rs1    <= rs1_id;
            r_rs2    <= rs2_id;
            r_rd     <= rd_id;
            r_rf_we  <= rf_we_id;
            r_mem_rd <= mem_rd_id;
        end
    end

    always_comb begin
        rD1_ex = r_rd1;
        if (w_mem_hit_rs1)     rD1_ex = wd_mem;
        else if (w_wb_hit_rs1) rD1_ex = wd_wb;

        rD2_fwd_ex = r_rd2;
        if (w_mem_hit_rs2)     rD2_fwd_ex = wd_mem;
        else if (w_wb_hit_rs2) rD2_fwd_ex = wd_wb;
    end

    assign alu_b_ex  = r_bsel ? r_imm : rD2_fwd_ex;
    assign valid_ex  = r_valid;
    assign alu_op_ex = r_alu_op;
    assign rd_ex     = r_rd;
    assign rf_we_ex  = r_rf_we & r_valid;
    assign mem_rd_ex = r_mem_rd & r_valid;

    assign load_use_stall = r_mem_rd && r_valid && (r_rd != '0) && valid_id &&
                            ((r_rd == rs1_id) || (r_rd == rs2_id));

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX-side outputs are queued when
// stimulus is applied and compared once the stage has produced them.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, valid_id;
    logic [4:0]  alu_op_id, rs1_id, rs2_id, rd_id, rd_mem, rd_wb;
    logic [31:0] rD1_id, rD2_id, imm_id, wd_mem, wd_wb;
    logic        alu_bsel_id, rf_we_id, mem_rd_id, rf_we_mem, mem_rd_mem, rf_we_wb;
    logic        valid_ex, rf_we_ex, mem_rd_ex, load_use_stall;
    logic [4:0]  alu_op_ex, rd_ex;
    logic [31:0] rD1_ex, rD2_fwd_ex, alu_b_ex;

    typedef struct packed {
        logic        valid;
        logic [4:0]  op;
        logic [31:0] d1;
        logic [31:0] d2f;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        mrd;
        logic        lus;
    } obs_t;

    typedef struct {
        string name;
        obs_t  v;
    } sb_t;

    sb_t  sb[$];
    sb_t  e;
    obs_t o;
    int   n_chk  = 0;
    int   n_fail = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_id(valid_id),
        .alu_op_id(alu_op_id), .rD1_id(rD1_id), .rD2_id(rD2_id), .imm_id(imm_id),
        .alu_bsel_id(alu_bsel_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .rf_we_id(rf_we_id), .mem_rd_id(mem_rd_id), .rd_mem(rd_mem), .rf_we_mem(rf_we_mem),
        .mem_rd_mem(mem_rd_mem), .wd_mem(wd_mem), .rd_wb(rd_wb), .rf_we_wb(rf_we_wb),
        .wd_wb(wd_wb), .valid_ex(valid_ex), .alu_op_ex(alu_op_ex), .rD1_ex(rD1_ex),
        .rD2_fwd_ex(rD2_fwd_ex), .alu_b_ex(alu_b_ex), .rd_ex(rd_ex), .rf_we_ex(rf_we_ex),
        .mem_rd_ex(mem_rd_ex), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic obs_t sample();
        return obs_t'({valid_ex, alu_op_ex, rD1_ex, rD2_fwd_ex, alu_b_ex, rd_ex,
                       rf_we_ex, mem_rd_ex, load_use_stall});
    endfunction

    function automatic sb_t mk(string name, logic v, logic [4:0] op, logic [31:0] d1,
                               logic [31:0] d2f, logic [31:0] b, logic [4:0] rd,
                               logic we, logic mrd, logic lus);
        sb_t t;
        t.name = name;
        t.v    = '{v, op, d1, d2f, b, rd, we, mrd, lus};
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] op, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] imm, input logic bsel,
                            input logic we, input logic mrd);
        valid_id = v;   alu_op_id = op; rs1_id = rs1; rs2_id = rs2; rd_id = rd;
        rD1_id = d1;    rD2_id = d2;    imm_id = imm; alu_bsel_id = bsel;
        rf_we_id = we;  mem_rd_id = mrd;
    endtask

    task automatic set_fwd(input logic [4:0] rdm, input logic wem, input logic mrdm,
                           input logic [31:0] wdm, input logic [4:0] rdw, input logic wew,
                           input logic [31:0] wdw);
        rd_mem = rdm; rf_we_mem = wem; mem_rd_mem = mrdm; wd_mem = wdm;
        rd_wb = rdw;  rf_we_wb = wew;  wd_wb = wdw;
    endtask

    task automatic test_reset();
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        stall = 0; flush = 0; rst_n = 0;
        drive_id(1, 5'd7, 1, 2, 4, 32'hAAAA, 32'hBBBB, 32'hCCCC, 1, 1, 1);
        sb.push_back(mk("reset_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick(); tick();
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        rst_n = 1;
        drive_id(1, 5'b00100, 1, 2, 9, 32'h8000_0000, 0, 32'h0000_0404, 1, 1, 0);
        sb.push_back(mk("first_capture", 1, 5'b00100, 32'h8000_0000, 0, 32'h404, 9, 1, 0, 0));
        tick();
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
    endtask

    task automatic test_forwarding();
        drive_id(1, 5'd1, 3, 4, 10, 32'h33, 32'h44, 0, 0, 1, 0);
        tick();
        set_fwd(3, 1, 0, 32'hDEAD_BEEF, 3, 1, 32'h1111_1111);
        sb.push_back(mk("mem_over_wb", 1, 1, 32'hDEAD_BEEF, 32'h44, 32'h44, 10, 1, 0, 0));
        #1;
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        mem_rd_mem = 1;
        sb.push_back(mk("mem_load_no_fwd", 1, 1, 32'h1111_1111, 32'h44, 32'h44, 10, 1, 0, 0));
        #1;
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        rf_we_wb = 0;
        sb.push_back(mk("no_fwd_reg", 1, 1, 32'h33, 32'h44, 32'h44, 10, 1, 0, 0));
        #1;
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        set_fwd(0, 0, 0, 0, 4, 1, 32'h5555_5555);
        sb.push_back(mk("wb_fwd_rs2", 1, 1, 32'h33, 32'h5555_5555, 32'h5555_5555, 10, 1, 0, 0));
        #1;
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
    endtask

    task automatic test_x0_guard();
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        drive_id(1, 5'd2, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        tick();
        set_fwd(0, 1, 0, 32'hFFFF_FFFF, 0, 1, 32'hEEEE_EEEE);
        sb.push_back(mk("x0_guard", 1, 2, 0, 0, 0, 1, 1, 0, 0));
        #1;
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
        set_fwd(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        drive_id(1, 5'd3, 1, 2, 5, 0, 0, 0, 0, 1, 1);
        tick();
        rs1_id = 6; rs2_id = 5; valid_id = 1;
        sb.push_back(mk("lu_rs2_hit", 1, 3, 0, 0, 0, 5, 1, 1, 1));
        #1;
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        rs2_id = 6;
        sb.push_back(mk("lu_no_match", 1, 3, 0, 0, 0, 5, 1, 1, 0));
        #1;
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        rs1_id = 5; valid_id = 0;
        sb.push_back(mk("lu_id_invalid", 1, 3, 0, 0, 0, 5, 1, 1, 0));
        #1;
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        drive_id(1, 5'd3, 1, 2, 0, 0, 0, 0, 0, 1, 1);
        tick();
        rs1_id = 0; rs2_id = 0;
        sb.push_back(mk("lu_rd_x0", 1, 3, 0, 0, 0, 0, 1, 1, 0));
        #1;
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        drive_id(1, 5'd3, 1, 2, 5, 0, 0, 0, 0, 1, 0);
        tick();
        rs2_id = 5;
        sb.push_back(mk("lu_not_load", 1, 3, 0, 0, 0, 5, 1, 0, 0));
        #1;
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        drive_id(1, 5'd3, 1, 2, 5, 0, 0, 0, 0, 1, 1);
        tick();
        rs1_id = 6; rs2_id = 5;
        stall = 1; flush = 1;
        sb.push_back(mk("lu_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
        stall = 0; flush = 0;
    endtask

    task automatic test_stall_refresh();
        drive_id(1, 5'd6, 7, 8, 12, 32'h77, 32'h88, 0, 0, 1, 0);
        tick();
        stall = 1;
        drive_id(1, 5'd9, 1, 1, 13, 32'h99, 0, 0, 0, 1, 0);
        sb.push_back(mk("stall_hold", 1, 6, 32'h77, 32'h88, 32'h88, 12, 1, 0, 0));
        tick();
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        set_fwd(0, 0, 0, 0, 7, 1, 32'h0000_00AA);
        sb.push_back(mk("stall_wb_fwd", 1, 6, 32'hAA, 32'h88, 32'h88, 12, 1, 0, 0));
        #1;
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        tick();
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        sb.push_back(mk("stall_refreshed", 1, 6, 32'hAA, 32'h88, 32'h88, 12, 1, 0, 0));
        #1;
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        sb.push_back(mk("stall_third", 1, 6, 32'hAA, 32'h88, 32'h88, 12, 1, 0, 0));
        tick();
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        stall = 0;
        sb.push_back(mk("stall_released", 1, 6, 32'hAA, 32'h88, 32'h88, 12, 1, 0, 0));
        #1;
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        sb.push_back(mk("after_stall", 1, 9, 32'h99, 0, 0, 13, 1, 0, 0));
        tick();
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
    endtask

    task automatic test_flush_priority();
        drive_id(1, 5'd5, 1, 2, 3, 32'h11, 32'h22, 0, 0, 1, 0);
        tick();
        stall = 1; flush = 1;
        drive_id(1, 5'd31, 1, 2, 3, 32'h11, 32'h22, 0, 0, 1, 1);
        sb.push_back(mk("flush_over_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        stall = 0;
        sb.push_back(mk("flush_alone", 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
        flush = 0;
    endtask

    task automatic test_reset_mid_stall();
        drive_id(1, 5'd5, 1, 2, 3, 32'h11, 32'h22, 0, 0, 1, 0);
        tick();
        stall = 1; rst_n = 0;
        sb.push_back(mk("reset_in_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

        rst_n = 1; stall = 0;
        sb.push_back(mk("post_reset_load", 1, 5, 32'h11, 32'h22, 32'h22, 3, 1, 0, 0));
        tick();
        e = sb.pop_front(); o = sample(); n_chk++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2, imm;
        logic        bsel;
        for (int i = 0; i < 6; i++) begin
            d1 = $urandom; d2 = $urandom; imm = $urandom; bsel = i[0];
            drive_id(1, 5'(i + 1), 5'(i + 10), 5'(i + 20), 5'(i + 1), d1, d2, imm, bsel, i[1], 0);
            sb.push_back(mk("b2b", 1, 5'(i + 1), d1, d2, bsel ? imm : d2, 5'(i + 1), i[1], 0, 0));
            tick();
            e = sb.pop_front(); o = sample(); n_chk++;
            if (o !== e.v) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, o, e.v); end
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_x0_guard();
        test_load_use();
        test_stall_refresh();
        test_flush_priority();
        test_reset_mid_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
